// File: rtl/hdlc_chk_pkg.sv
// Shared constants and types for the HDLC receiver checker.
// Line patterns, check indices and line-tracking states.
package hdlc_chk_pkg;

    localparam logic [7:0] FLAG_PAT  = 8'b0111_1110;
    localparam logic [7:0] ABORT_PAT = 8'b0111_1111;
    localparam logic [7:0] IDLE_PAT  = 8'hFF;

    localparam int CHK_FLAG  = 0;
    localparam int CHK_ABORT = 1;
    localparam int CHK_EOF   = 2;
    localparam int NUM_CHK   = 3;

    typedef enum logic [1:0] {
        LS_IDLE     = 2'd0,
        LS_FLAGGED  = 2'd1,
        LS_IN_FRAME = 2'd2
    } line_state_e;

endpackage

// File: rtl/hdlc_chk_delay.sv
// Fixed-latency shift line carrying check launches to their evaluation cycle.
// Each stage holds one launch, so back-to-back launches never collide.
module hdlc_chk_delay #(
    parameter int LAT = 1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic launch_i,
    output logic due_o
);

    logic [LAT-1:0] line_q;
    logic [LAT-1:0] line_d;

    always_comb begin
        line_d = LAT'({line_q, launch_i});
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign due_o = line_q[LAT-1];

endmodule

// File: rtl/hdlc_rx_checker.sv
// Passive checker for an HDLC receiver: flag/abort/EoF response timing,
// error strobes, sticky flags, saturating counters and line tracking.
module hdlc_rx_checker
    import hdlc_chk_pkg::*;
#(
    parameter int FLAG_LAT  = 2,
    parameter int ABORT_LAT = 1,
    parameter int EOF_LAT   = 1,
    parameter int CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             ClrCnt,
    input  logic             Rx,
    input  logic             Rx_FlagDetect,
    input  logic             Rx_AbortDetect,
    input  logic             Rx_AbortSignal,
    input  logic             Rx_ValidFrame,
    input  logic             Rx_EoF,
    output logic [2:0]       ErrPulse,
    output logic [2:0]       ErrSticky,
    output logic [CNT_W-1:0] ErrCntFlag,
    output logic [CNT_W-1:0] ErrCntAbort,
    output logic [CNT_W-1:0] ErrCntEof,
    output logic [CNT_W-1:0] ErrCntTotal,
    output logic [CNT_W-1:0] FrameCnt,
    output logic [1:0]       LineState
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0]       hist_q, hist_d;
    logic             vf_q, vf_d;
    logic             ad_q, ad_d;
    logic [2:0]       pulse_q, pulse_d;
    logic [2:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] err_cnt_q [NUM_CHK];
    logic [CNT_W-1:0] err_cnt_d [NUM_CHK];
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [2:0]       quiet_q, quiet_d;
    line_state_e      line_q, line_d;

    logic [7:0]       win;
    logic             flag_hit, abort_hit, idle_hit;
    logic [2:0]       launch, due, obs, err;
    logic [1:0]       n_err;
    logic [CNT_W+1:0] tot_sum;
    logic             frame_inc;

    // Window includes the bit arriving this cycle.
    assign win       = {hist_q, Rx};
    assign flag_hit  = (win == FLAG_PAT);
    assign abort_hit = (win == ABORT_PAT);
    assign idle_hit  = (win == IDLE_PAT);

    assign launch[CHK_FLAG]  = Enable & flag_hit;
    assign launch[CHK_ABORT] = Enable & Rx_AbortDetect & Rx_ValidFrame;
    assign launch[CHK_EOF]   = Enable & vf_q & ~Rx_ValidFrame & ~ad_q;

    hdlc_chk_delay #(.LAT(FLAG_LAT)) u_dly_flag (
        .Clk      (Clk),
        .Rst      (Rst),
        .launch_i (launch[CHK_FLAG]),
        .due_o    (due[CHK_FLAG])
    );

    hdlc_chk_delay #(.LAT(ABORT_LAT)) u_dly_abort (
        .Clk      (Clk),
        .Rst      (Rst),
        .launch_i (launch[CHK_ABORT]),
        .due_o    (due[CHK_ABORT])
    );

    hdlc_chk_delay #(.LAT(EOF_LAT)) u_dly_eof (
        .Clk      (Clk),
        .Rst      (Rst),
        .launch_i (launch[CHK_EOF]),
        .due_o    (due[CHK_EOF])
    );

    assign obs = {Rx_EoF, Rx_AbortSignal, Rx_FlagDetect};
    assign err = due & ~obs;

    always_comb begin
        line_d    = line_q;
        quiet_d   = quiet_q;
        frame_inc = 1'b0;
        if (abort_hit || idle_hit) begin
            line_d = LS_IDLE;
        end else if (flag_hit) begin
            line_d    = LS_FLAGGED;
            quiet_d   = '0;
            frame_inc = (line_q == LS_IN_FRAME);
        end else begin
            case (line_q)
                LS_FLAGGED: begin
                    if (quiet_q == 3'd7) begin
                        line_d = LS_IN_FRAME;
                    end else begin
                        quiet_d = quiet_q + 3'd1;
                    end
                end
                default: begin
                    line_d = line_q;
                end
            endcase
        end
    end

    always_comb begin
        hist_d   = win[6:0];
        vf_d     = Rx_ValidFrame;
        ad_d     = Rx_AbortDetect;
        pulse_d  = err;
        n_err    = {1'b0, err[0]} + {1'b0, err[1]} + {1'b0, err[2]};
        tot_sum  = {2'b00, tot_q} + {{CNT_W{1'b0}}, n_err};
        sticky_d = sticky_q | err;
        tot_d    = (tot_sum > {2'b00, CNT_MAX}) ? CNT_MAX
                                                : tot_sum[CNT_W-1:0];
        frame_d  = (frame_inc && frame_q != CNT_MAX) ? frame_q + CNT_W'(1)
                                                     : frame_q;
        for (int i = 0; i < NUM_CHK; i++) begin
            err_cnt_d[i] = (err[i] && err_cnt_q[i] != CNT_MAX)
                         ? err_cnt_q[i] + CNT_W'(1) : err_cnt_q[i];
        end
        // Clearing beats any increment landing in the same cycle.
        if (ClrCnt) begin
            sticky_d = '0;
            tot_d    = '0;
            frame_d  = '0;
            for (int i = 0; i < NUM_CHK; i++) begin
                err_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hist_q   <= '1;
            vf_q     <= 1'b0;
            ad_q     <= 1'b0;
            pulse_q  <= '0;
            sticky_q <= '0;
            tot_q    <= '0;
            frame_q  <= '0;
            quiet_q  <= '0;
            line_q   <= LS_IDLE;
            for (int i = 0; i < NUM_CHK; i++) begin
                err_cnt_q[i] <= '0;
            end
        end else begin
            hist_q   <= hist_d;
            vf_q     <= vf_d;
            ad_q     <= ad_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            tot_q    <= tot_d;
            frame_q  <= frame_d;
            quiet_q  <= quiet_d;
            line_q   <= line_d;
            for (int i = 0; i < NUM_CHK; i++) begin
                err_cnt_q[i] <= err_cnt_d[i];
            end
        end
    end

    assign ErrPulse    = pulse_q;
    assign ErrSticky   = sticky_q;
    assign ErrCntFlag  = err_cnt_q[CHK_FLAG];
    assign ErrCntAbort = err_cnt_q[CHK_ABORT];
    assign ErrCntEof   = err_cnt_q[CHK_EOF];
    assign ErrCntTotal = tot_q;
    assign FrameCnt    = frame_q;
    assign LineState   = line_q;

endmodule

// File: doc/hdlc_rx_checker.md
HDLC_RX_CHECKER -- requirements
Module: hdlc_rx_checker

Interface
REQ-001 Parameter FLAG_LAT, default 2, cycles from last flag bit on Rx to required Rx_FlagDetect; legal range 1..8.
REQ-002 Parameter ABORT_LAT, default 1, cycles from (Rx_AbortDetect && Rx_ValidFrame) to required Rx_AbortSignal; legal range 1..8.
REQ-003 Parameter EOF_LAT, default 1, cycles from Rx_ValidFrame falling to required Rx_EoF; legal range 1..8.
REQ-004 Parameter CNT_W, default 16, width of every error and frame counter.
REQ-005 Clk  in  1  single clock; all logic on posedge Clk.
REQ-006 Rst  in  1  reset, synchronous, active-high.
REQ-007 Enable  in  1  high permits launching new checks.
REQ-008 ClrCnt  in  1  synchronous clear of counters and sticky flags.
REQ-009 Rx  in  1  serial HDLC line, one bit per cycle.
REQ-010 Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_EoF  in  1 each  observed receiver status.
REQ-011 ErrPulse  out  3  one-cycle error strobe per check: [0] flag, [1] abort, [2] EoF.
REQ-012 ErrSticky  out  3  sticky per-check error flag.
REQ-013 ErrCntFlag, ErrCntAbort, ErrCntEof, ErrCntTotal  out  CNT_W each  saturating error counts.
REQ-014 FrameCnt  out  CNT_W  saturating count of completed frames.
REQ-015 LineState  out  2  current line-tracking FSM state.

Function
REQ-016 History register shifts Rx in each cycle; cycle c is a flag hit when Rx over cycles c-7..c equals 0,1,1,1,1,1,1,0; abort hit when 0 followed by seven 1s; idle hit when eight consecutive 1s.
REQ-017 Flag check: flag hit at cycle c with Enable high at c launches an expectation; Rx_FlagDetect low at c+FLAG_LAT is a flag error.
REQ-018 Abort check: Rx_AbortDetect && Rx_ValidFrame at c with Enable high launches an expectation; Rx_AbortSignal low at c+ABORT_LAT is an abort error.
REQ-019 EoF check: Rx_ValidFrame high at c-1 and low at c, Rx_AbortDetect low at c-1, Enable high at c launches an expectation; Rx_EoF low at c+EOF_LAT is an EoF error.
REQ-020 Expectations are pipelined; back-to-back launches each checked independently, no loss.
REQ-021 Enable deassertion blocks new launches only; in-flight expectations still complete and report.
REQ-022 On an error: ErrPulse bit high for exactly the evaluation cycle+1 (registered), ErrSticky bit set, per-check counter +1.
REQ-023 ErrCntTotal adds the number of simultaneous errors (0..3) in one cycle.
REQ-024 All counters saturate at 2^CNT_W-1; no wrap.
REQ-025 ClrCnt zeroes all counters and ErrSticky; ClrCnt wins over a coincident increment; history, FSM and pending expectations unaffected.
REQ-026 LineState FSM: IDLE(0), FLAGGED(1), IN_FRAME(2); IDLE->FLAGGED on flag hit; FLAGGED->IN_FRAME after 8 cycles with no flag hit; FLAGGED stays on repeated flags; IN_FRAME->FLAGGED on flag hit with FrameCnt +1; any state->IDLE on abort or idle hit; abort and idle take priority over flag.
REQ-027 Checks are passive: no output influences the observed DUT.

Reset
REQ-028 Rst high at a posedge clears history to all ones, LineState to IDLE, all pending expectations, ErrPulse, ErrSticky and all counters to 0.
REQ-029 Reset mid-operation drops in-flight expectations without reporting errors; Rst overrides ClrCnt and Enable.

Structure
REQ-030 Package hdlc_chk_pkg holds FLAG_PAT 8'b0111_1110, ABORT_PAT 8'b0111_1111, IDLE_PAT 8'hFF, check-index constants (FLAG=0, ABORT=1, EOF=2) and the LineState enum.
REQ-031 Sub-module hdlc_chk_delay (parameter LAT, shift line of launch bits) instantiated once per check.

Verification
REQ-032 Rx drives 0111_1110 ending cycle c, Rx_FlagDetect high at c+2 -> no error; repeat with Rx_FlagDetect low -> ErrPulse[0] once, ErrCntFlag=1, ErrSticky=3'b001.
REQ-033 Rx_AbortDetect=Rx_ValidFrame=1 at c, Rx_AbortSignal low at c+1 -> ErrCntAbort=1, ErrCntTotal=1.
REQ-034 Rx_ValidFrame falls at c, Rx_EoF at c+1 -> no error; fall one cycle after Rx_AbortDetect -> no expectation, no error.
REQ-035 Flag, 16 data bits (no six-ones run), flag, 8 data bits, abort -> FrameCnt=1, LineState IDLE.
REQ-036 CNT_W=2, five consecutive flag errors -> ErrCntFlag=3; ClrCnt coincident with a sixth error -> ErrCntFlag=0, ErrSticky=0.
REQ-037 Flag launched, Rst at c+1, Rx_FlagDetect low at c+2 -> no error, all outputs 0.
